// File: rtl/aes_ct_collector.sv
// aes_ct_collector - buffers aes_api cipher pulses and re-frames each message
// as header beats + byte-swapped cipher beats + tag beat on a valid/ready stream.
module aes_ct_collector #(
  parameter int DEPTH      = 8,
  parameter int BYPASS_W   = 289,
  parameter int SWAP_BYTES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_cp_ready,
  input  logic [127:0]        i_cipher_text,
  input  logic [BYPASS_W-1:0] i_bypass_text,
  input  logic                i_last,
  input  logic                i_tag_valid,
  input  logic [127:0]        i_tag,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [127:0]        o_data,
  output logic                o_first,
  output logic                o_last,
  output logic                o_overflow
);

  localparam int AW        = $clog2(DEPTH);
  localparam int HDR_BEATS = (BYPASS_W + 127) / 128;
  localparam int HW        = HDR_BEATS * 128;
  localparam int BW        = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TAG} state_t;

  function automatic logic [127:0] f_swap(input logic [127:0] d);
    logic [127:0] r;
    r = d;
    if (SWAP_BYTES != 0) begin
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = d[(15-i)*8 +: 8];
    end
    return r;
  endfunction

  logic [128:0]  r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [HW-1:0] r_hdr;
  logic          r_hdr_pending, r_expect_first;
  logic [127:0]  r_tag;
  logic          r_tag_full;
  logic          r_overflow;
  state_t        r_state;
  logic [BW-1:0] r_beat_cnt;
  logic          r_valid, r_first, r_last, r_head_last;
  logic [127:0]  r_data;

  state_t        w_nx_state;
  logic [BW-1:0] w_nx_beat;
  logic          w_nx_valid, w_nx_first, w_nx_last, w_nx_head_last;
  logic [127:0]  w_nx_data;

  logic          w_accept, w_full, w_pop, w_push, w_nonempty_next;
  logic [AW:0]   w_rd_next, w_wr_next;
  logic [128:0]  w_head_next;
  logic          w_tag_clr, w_tag_full_nx, w_hdr_clr, w_first_blk;
  logic [127:0]  w_tag_nx;
  logic [BW-1:0] w_beat_inc;
  logic [127:0]  w_hdr_beats [HDR_BEATS];

  assign w_accept  = r_valid & i_ready;
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = (r_state == S_DATA) & w_accept;
  assign w_push    = i_cp_ready & (!w_full | w_pop);
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_nonempty_next = (w_rd_next != w_wr_next);
  // The next head may be the very block being written this edge.
  assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? {i_last, i_cipher_text}
                                                          : r_mem[w_rd_next[AW-1:0]];

  assign w_tag_clr     = (r_state == S_TAG) & w_accept;
  assign w_tag_full_nx = r_tag_full ? !w_tag_clr : i_tag_valid;
  assign w_tag_nx      = r_tag_full ? r_tag : i_tag;

  assign w_beat_inc  = r_beat_cnt + 1'b1;
  assign w_hdr_clr   = (r_state == S_HDR) & w_accept & (r_beat_cnt == BW'(HDR_BEATS - 1));
  assign w_first_blk = w_push & r_expect_first;

  for (genvar g = 0; g < HDR_BEATS; g++) begin : g_hdr
    assign w_hdr_beats[g] = r_hdr[(HDR_BEATS-1-g)*128 +: 128];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_last, i_cipher_text};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_hdr          <= '0;
      r_hdr_pending  <= 1'b0;
      r_expect_first <= 1'b1;
      r_tag          <= '0;
      r_tag_full     <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (i_cp_ready && !w_push) r_overflow <= 1'b1;
      if (w_push) begin
        if (i_last)              r_expect_first <= 1'b1;
        else if (r_expect_first) r_expect_first <= 1'b0;
      end
      if (w_hdr_clr) r_hdr_pending <= 1'b0;
      // A header being retired this edge frees the register for the new one.
      if (w_first_blk) begin
        if (r_hdr_pending && !w_hdr_clr) begin
          r_overflow <= 1'b1;
        end else begin
          r_hdr         <= HW'(i_bypass_text);
          r_hdr_pending <= 1'b1;
        end
      end
      if (i_tag_valid) begin
        if (r_tag_full) begin
          r_overflow <= 1'b1;
          if (w_tag_clr) r_tag_full <= 1'b0;
        end else begin
          r_tag      <= i_tag;
          r_tag_full <= 1'b1;
        end
      end else if (w_tag_clr) begin
        r_tag_full <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nx_state     = r_state;
    w_nx_beat      = r_beat_cnt;
    w_nx_valid     = r_valid;
    w_nx_data      = r_data;
    w_nx_first     = r_first;
    w_nx_last      = r_last;
    w_nx_head_last = r_head_last;
    case (r_state)
      S_IDLE: begin
        w_nx_valid = 1'b0;
        if (r_hdr_pending) begin
          w_nx_state = S_HDR;
          w_nx_beat  = '0;
          w_nx_valid = 1'b1;
          w_nx_data  = w_hdr_beats[0];
          w_nx_first = 1'b1;
          w_nx_last  = 1'b0;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          w_nx_first = 1'b0;
          if (r_beat_cnt == BW'(HDR_BEATS - 1)) begin
            w_nx_state     = S_DATA;
            w_nx_valid     = w_nonempty_next;
            w_nx_data      = f_swap(w_head_next[127:0]);
            w_nx_head_last = w_head_next[128];
          end else begin
            w_nx_beat = w_beat_inc;
            w_nx_data = w_hdr_beats[w_beat_inc];
          end
        end
      end
      S_DATA: begin
        if (w_accept && r_head_last) begin
          w_nx_state = S_TAG;
          w_nx_valid = w_tag_full_nx;
          w_nx_data  = w_tag_nx;
          w_nx_last  = 1'b1;
        end else if (!r_valid || w_accept) begin
          w_nx_valid     = w_nonempty_next;
          w_nx_data      = f_swap(w_head_next[127:0]);
          w_nx_head_last = w_head_next[128];
        end
      end
      S_TAG: begin
        if (w_accept) begin
          w_nx_state = S_IDLE;
          w_nx_valid = 1'b0;
          w_nx_last  = 1'b0;
        end else if (!r_valid) begin
          w_nx_valid = w_tag_full_nx;
          w_nx_data  = w_tag_nx;
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_head_last <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_beat_cnt  <= w_nx_beat;
      r_valid     <= w_nx_valid;
      r_data      <= w_nx_data;
      r_first     <= w_nx_first;
      r_last      <= w_nx_last;
      r_head_last <= w_nx_head_last;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_first    = r_first;
  assign o_last     = r_last;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_aes_ct_collector.sv
// tb/tb_aes_ct_collector.sv - scoreboard bench for aes_ct_collector (swap and no-swap instances).
module tb_aes_ct_collector;
  localparam int DEPTH = 8;
  localparam int BW    = 289;
  localparam int HB    = (BW + 127) / 128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_cp_ready = 1'b0;
  logic [127:0]  i_cipher_text = '0;
  logic [BW-1:0] i_bypass_text = '0;
  logic          i_last = 1'b0;
  logic          i_tag_valid = 1'b0;
  logic [127:0]  i_tag = '0;
  logic          i_ready = 1'b0;
  logic          o_valid, o_first, o_last, o_overflow;
  logic [127:0]  o_data;
  logic          n_valid, n_first, n_last, n_overflow;
  logic [127:0]  n_data;

  aes_ct_collector #(.DEPTH(DEPTH), .BYPASS_W(BW), .SWAP_BYTES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_cp_ready(i_cp_ready), .i_cipher_text(i_cipher_text),
    .i_bypass_text(i_bypass_text), .i_last(i_last), .i_tag_valid(i_tag_valid), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_first(o_first),
    .o_last(o_last), .o_overflow(o_overflow));

  aes_ct_collector #(.DEPTH(DEPTH), .BYPASS_W(BW), .SWAP_BYTES(0)) u_dut_ns (
    .clk(clk), .reset_n(reset_n), .i_cp_ready(i_cp_ready), .i_cipher_text(i_cipher_text),
    .i_bypass_text(i_bypass_text), .i_last(i_last), .i_tag_valid(i_tag_valid), .i_tag(i_tag),
    .o_valid(n_valid), .i_ready(i_ready), .o_data(n_data), .o_first(n_first),
    .o_last(n_last), .o_overflow(n_overflow));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [127:0] dn;
    logic         first;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] blk_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           rdy_mode = 1;
  logic         hold_chk = 1'b0;
  logic [127:0] held_data = '0;

  function automatic logic [127:0] swap16(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_byp();
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
    return r[BW-1:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Reference framing: zero-extended header split MS beat first, blocks swapped, tag raw.
  task automatic exp_frame(input logic [BW-1:0] byp, input logic [127:0] tag);
    logic [HB*128-1:0] ext;
    logic [HB*128-1:0] sh;
    beat_t b;
    ext = {{(HB*128-BW){1'b0}}, byp};
    for (int k = 0; k < HB; k++) begin
      sh = ext >> (128 * (HB - 1 - k));
      b.d = sh[127:0]; b.dn = sh[127:0]; b.first = (k == 0); b.last = 1'b0;
      exp_q.push_back(b);
    end
    foreach (blk_q[i]) begin
      b.d = swap16(blk_q[i]); b.dn = blk_q[i]; b.first = 1'b0; b.last = 1'b0;
      exp_q.push_back(b);
    end
    b.d = tag; b.dn = tag; b.first = 1'b0; b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_blk(input logic [127:0] d, input logic last, input logic [BW-1:0] byp);
    i_cp_ready = 1'b1; i_cipher_text = d; i_last = last; i_bypass_text = byp;
    tick();
    i_cp_ready = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] t);
    i_tag_valid = 1'b1; i_tag = t;
    tick();
    i_tag_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d beats still owed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_valid"}, 128'(o_valid), 128'd0);
    chk({nm, "_data"}, o_data, 128'd0);
    chk({nm, "_first"}, 128'(o_first), 128'd0);
    chk({nm, "_last"}, 128'(o_last), 128'd0);
    chk({nm, "_ovf"}, 128'(o_overflow), 128'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 2) i_ready = 1'($urandom);
    else               i_ready = (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        vectors++;
        if (!o_valid || o_data !== held_data) begin
          miscompares++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", o_valid, o_data, held_data);
        end
      end
      vectors++;
      if (n_valid !== o_valid) begin
        miscompares++;
        $display("FAIL twin_valid: noswap=%b required %b", n_valid, o_valid);
      end
      if (o_valid && i_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_beat: got %h with nothing expected", o_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (o_data !== e.d || n_data !== e.dn || o_first !== e.first || o_last !== e.last ||
              n_first !== e.first || n_last !== e.last) begin
            miscompares++;
            $display("FAIL beat: got %h/%h f%b l%b required %h/%h f%b l%b",
                     o_data, n_data, o_first, o_last, e.d, e.dn, e.first, e.last);
          end
        end
      end
      hold_chk  = o_valid && !i_ready;
      held_data = o_data;
    end
  end

  initial begin
    logic [BW-1:0]  byp;
    logic [127:0]   tag;
    logic [127:0]   blk;
    int             len, n;
    logic           early;

    reset_n = 1'b0;
    tick(); tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Directed single-block message with known byte-swapped result
    rdy_mode = 1;
    byp = {1'b1, 128'hD9313225F88406E5A55909C5AFF5269A, 128'h0123456789ABCDEF0011223344556677, 32'h0000069A};
    blk = 128'h9A26F5AFC50959A5E50684F8253231D9;
    tag = 128'h4D5C2AF3_0BADF00D_12345678_0000002B;
    blk_q = '{blk};
    exp_frame(byp, tag);
    exp_q[HB].d = 128'hD9313225F88406E5A55909C5AFF5269A;
    send_blk(blk, 1'b1, byp);
    send_tag(tag);
    wait_drain(200);

    // Four blocks held behind a stalled sink
    rdy_mode = 0;
    byp = rand_byp(); tag = rand128();
    blk_q.delete();
    for (int i = 0; i < 4; i++) blk_q.push_back(rand128());
    exp_frame(byp, tag);
    for (int i = 0; i < 4; i++) send_blk(blk_q[i], i == 3, byp);
    send_tag(tag);
    repeat (20) tick();
    chk("stall_no_ovf", 128'(o_overflow), 128'd0);
    rdy_mode = 1;
    wait_drain(200);

    // DEPTH+1 blocks into a stalled sink: the extra one is dropped
    rdy_mode = 0;
    byp = rand_byp(); tag = rand128();
    blk_q.delete();
    for (int i = 0; i < DEPTH; i++) blk_q.push_back(rand128());
    exp_frame(byp, tag);
    for (int i = 0; i < DEPTH; i++) send_blk(blk_q[i], i == DEPTH - 1, byp);
    send_blk(rand128(), 1'b1, rand_byp());
    send_tag(tag);
    tick();
    chk("full_ovf", 128'(o_overflow), 128'd1);
    rdy_mode = 1;
    wait_drain(300);
    chk("full_ovf_sticky", 128'(o_overflow), 128'd1);
    do_reset();
    chk("ovf_cleared", 128'(o_overflow), 128'd0);

    // Tag before the last block, then a second tag that must be dropped
    rdy_mode = 2;
    byp = rand_byp(); tag = rand128();
    blk_q = '{rand128(), rand128(), rand128()};
    exp_frame(byp, tag);
    send_blk(blk_q[0], 1'b0, byp);
    send_blk(blk_q[1], 1'b0, byp);
    send_tag(tag);
    send_tag(rand128());
    tick();
    send_blk(blk_q[2], 1'b1, byp);
    wait_drain(400);
    chk("tag_ovf", 128'(o_overflow), 128'd1);
    do_reset();

    // Ordered byte pattern exercises lane mapping on both instances
    rdy_mode = 1;
    byp = rand_byp(); tag = rand128();
    blk_q = '{128'h000102030405060708090A0B0C0D0E0F};
    exp_frame(byp, tag);
    send_blk(blk_q[0], 1'b1, byp);
    send_tag(tag);
    wait_drain(200);

    // Reset in the middle of the data phase with three blocks still buffered
    rdy_mode = 0;
    byp = rand_byp();
    blk_q.delete();
    for (int i = 0; i < 4; i++) blk_q.push_back(rand128());
    exp_frame(byp, rand128());
    for (int i = 0; i < 4; i++) send_blk(blk_q[i], i == 3, byp);
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() > 4 && n < 100) begin tick(); n++; end
    rdy_mode = 0;
    chk("mid_data_reached", 128'(exp_q.size()), 128'd4);
    tick();
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    rdy_mode = 1;
    byp = rand_byp(); tag = rand128();
    blk_q = '{rand128(), rand128()};
    exp_frame(byp, tag);
    send_blk(blk_q[0], 1'b0, byp);
    send_blk(blk_q[1], 1'b1, byp);
    send_tag(tag);
    wait_drain(200);

    // Randomized messages with random sink stalls and tag placement
    rdy_mode = 2;
    for (int m = 0; m < 15; m++) begin
      byp = rand_byp(); tag = rand128();
      len = $urandom_range(1, DEPTH);
      early = (len > 1) && 1'($urandom);
      blk_q.delete();
      for (int i = 0; i < len; i++) blk_q.push_back(rand128());
      exp_frame(byp, tag);
      for (int i = 0; i < len; i++) begin
        if (early && i == len - 1) send_tag(tag);
        send_blk(blk_q[i], i == len - 1, byp);
        repeat ($urandom_range(0, 2)) tick();
      end
      if (!early) send_tag(tag);
      wait_drain(600);
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("random_no_ovf", 128'(o_overflow), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
